vblank_task_scheduler: RTL and testbench

VBLANK_TASK_SCHEDULER -- requirements
Module: vblank_task_scheduler

---
 rtl/vblank_task_scheduler_pkg.sv | 20 ++
 rtl/vblank_task_scheduler_if.sv | 29 ++
 rtl/vblank_task_scheduler_prio_enc.sv | 14 +
 rtl/vblank_task_scheduler.sv | 130 +++++++++++++
 tb/tb_vblank_task_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vblank_task_scheduler_pkg.sv
// Shared constants, FSM state encoding and watchdog sizing for the vblank task scheduler.
package vblank_task_scheduler_pkg;

    localparam int NUM_TASKS_DEF      = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int OVR_W              = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK  = 2'd1,
        ST_GRANT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Watchdog counts 0..cycles-1; a single-cycle timeout still needs one bit.
    function automatic int wd_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/vblank_task_scheduler_if.sv
// Request/grant and status bundle between the blanking scheduler and its requesters.
interface vblank_task_scheduler_if
    import vblank_task_scheduler_pkg::*;
#(
    parameter int N = NUM_TASKS_DEF
) ();

    logic             i_update;
    logic             i_enable;
    logic [N-1:0]     i_task_req;
    logic [N-1:0]     i_task_done;
    logic             i_clear_flags;
    logic [N-1:0]     o_task_grant;
    logic             o_busy;
    logic             o_frame_done;
    logic [N-1:0]     o_timeout_flags;
    logic [OVR_W-1:0] o_overrun_cnt;

    modport master (
        output i_update, i_enable, i_task_req, i_task_done, i_clear_flags,
        input  o_task_grant, o_busy, o_frame_done, o_timeout_flags, o_overrun_cnt
    );

    modport slave (
        input  i_update, i_enable, i_task_req, i_task_done, i_clear_flags,
        output o_task_grant, o_busy, o_frame_done, o_timeout_flags, o_overrun_cnt
    );

endinterface

// File: rtl/vblank_task_scheduler_prio_enc.sv
// Lowest-set-bit picker: one-hot of the lowest pending task plus a valid flag; purely combinational.
module task_priority_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_mask,
    output logic [N-1:0] o_onehot,
    output logic         o_vld
);

    // Two's-complement trick isolates the lowest set bit.
    assign o_onehot = i_mask & ((~i_mask) + N'(1));
    assign o_vld    = |i_mask;

endmodule

// File: rtl/vblank_task_scheduler.sv
// Serves latched task requests one at a time during vertical blanking, grant 2 cycles after update.
// No backpressure: a grant ends on task_done or watchdog expiry; updates while busy are only counted.
module vblank_task_scheduler
    import vblank_task_scheduler_pkg::*;
#(
    parameter int NUM_TASKS      = NUM_TASKS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vblank_task_scheduler_if.slave  bus
);

    localparam int             WD_W    = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    logic [NUM_TASKS-1:0] r_pending;
    logic [NUM_TASKS-1:0] r_grant;
    logic [NUM_TASKS-1:0] r_flags;
    logic [WD_W-1:0]      r_wd;
    logic [OVR_W-1:0]     r_ovr;
    logic                 r_busy;
    logic                 r_frame_done;

    logic [NUM_TASKS-1:0] w_pick_onehot;
    logic                 w_pick_vld;
    logic                 w_start;
    logic                 w_overrun;
    logic                 w_done;
    logic                 w_timeout;
    logic [NUM_TASKS-1:0] w_new_flag;
    state_t               w_next;
    logic [NUM_TASKS-1:0] w_next_pending;

    task_priority_enc #(.N(NUM_TASKS)) u_prio_enc (
        .i_mask   (r_pending),
        .o_onehot (w_pick_onehot),
        .o_vld    (w_pick_vld)
    );

    assign w_start    = (r_state == ST_IDLE) && bus.i_update && bus.i_enable;
    assign w_overrun  = (r_state != ST_IDLE) && bus.i_update && bus.i_enable;
    assign w_done     = (r_state == ST_GRANT) && |(bus.i_task_done & r_grant);
    // Done has priority over an expiring watchdog in the same cycle.
    assign w_timeout  = (r_state == ST_GRANT) && !w_done && (r_wd == WD_LAST);
    assign w_new_flag = w_timeout ? r_grant : '0;

    always_comb begin
        w_next         = r_state;
        w_next_pending = r_pending;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next         = ST_PICK;
                    w_next_pending = bus.i_task_req;
                end
            end
            ST_PICK: begin
                if (w_pick_vld) begin
                    w_next         = ST_GRANT;
                    w_next_pending = r_pending & ~w_pick_onehot;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_done || w_timeout) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                w_next = ST_PICK;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_grant      <= '0;
            r_flags      <= '0;
            r_wd         <= '0;
            r_ovr        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_next_pending;
            r_busy    <= (w_next != ST_IDLE);
            // Registered so the pulse lines up with the PICK cycle that finds nothing left.
            r_frame_done <= (w_next == ST_PICK) && (w_next_pending == '0);

            if ((r_state == ST_PICK) && w_pick_vld) begin
                r_grant <= w_pick_onehot;
            end else if (w_done || w_timeout) begin
                r_grant <= '0;
            end

            if ((r_state == ST_GRANT) && !w_done && !w_timeout) begin
                r_wd <= r_wd + WD_W'(1);
            end else begin
                r_wd <= '0;
            end

            r_flags <= (bus.i_clear_flags ? '0 : r_flags) | w_new_flag;

            if (w_overrun) begin
                if (bus.i_clear_flags) begin
                    r_ovr <= OVR_W'(1);
                end else if (r_ovr != {OVR_W{1'b1}}) begin
                    r_ovr <= r_ovr + OVR_W'(1);
                end
            end else if (bus.i_clear_flags) begin
                r_ovr <= '0;
            end
        end
    end

    assign bus.o_task_grant    = r_grant;
    assign bus.o_busy          = r_busy;
    assign bus.o_frame_done    = r_frame_done;
    assign bus.o_timeout_flags = r_flags;
    assign bus.o_overrun_cnt   = r_ovr;

endmodule

// File: tb/tb_vblank_task_scheduler.sv
// Bench for vblank_task_scheduler: fixed vector table, directed corner sequences and random traffic vs. a queue-based model.
module tb_vblank_task_scheduler;

    localparam int NT = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vblank_task_scheduler_if #(.N(NT)) bus ();

    vblank_task_scheduler #(.NUM_TASKS(NT), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: a frame is a queue of task indices served in order; m_cd counts gap cycles before the next pick.
    bit         m_active;
    int         m_todo[$];
    int         m_cur;
    int         m_age;
    int         m_cd;
    logic [3:0] m_flags;
    int         m_ovr;
    bit         m_fd;

    function automatic void model_reset();
        m_active = 1'b0;
        m_todo.delete();
        m_cur    = -1;
        m_age    = 0;
        m_cd     = 0;
        m_flags  = '0;
        m_ovr    = 0;
        m_fd     = 1'b0;
    endfunction

    function automatic void model_step(input bit u, input bit e, input logic [3:0] r,
                                       input logic [3:0] d, input bit c);
        logic [3:0] newf;
        bit         ovr_ev;
        newf   = '0;
        ovr_ev = 1'b0;
        if (!m_active) begin
            if (u && e) begin
                m_active = 1'b1;
                m_todo.delete();
                for (int i = 0; i < NT; i++) if (r[i]) m_todo.push_back(i);
                m_cur = -1;
                m_cd  = 0;
            end
        end else begin
            if (u && e) ovr_ev = 1'b1;
            if (m_cur >= 0) begin
                if (d[m_cur]) begin
                    m_cur = -1;
                    m_cd  = 1;
                end else if (m_age == TO - 1) begin
                    newf[m_cur] = 1'b1;
                    m_cur = -1;
                    m_cd  = 1;
                end else begin
                    m_age++;
                end
            end else if (m_cd > 0) begin
                m_cd--;
            end else if (m_todo.size() == 0) begin
                m_active = 1'b0;
            end else begin
                m_cur = m_todo.pop_front();
                m_age = 0;
            end
        end
        m_flags = (c ? 4'b0000 : m_flags) | newf;
        if (ovr_ev) m_ovr = c ? 1 : ((m_ovr < 255) ? m_ovr + 1 : 255);
        else if (c) m_ovr = 0;
        m_fd = m_active && (m_cur < 0) && (m_cd == 0) && (m_todo.size() == 0);
    endfunction

    function automatic void chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endfunction

    task automatic step();
        logic [3:0] eg;
        @(posedge clk);
        model_step(bus.i_update, bus.i_enable, bus.i_task_req, bus.i_task_done, bus.i_clear_flags);
        #1;
        eg = '0;
        if (m_cur >= 0) eg[m_cur] = 1'b1;
        chk("grant",      int'(bus.o_task_grant), int'(eg));
        chk("busy",       int'(bus.o_busy), int'(m_active));
        chk("frame_done", int'(bus.o_frame_done), int'(m_fd));
        chk("flags",      int'(bus.o_timeout_flags), int'(m_flags));
        chk("overrun",    int'(bus.o_overrun_cnt), m_ovr);
        chk("onehot",     int'($countones(bus.o_task_grant) <= 1), 1);
    endtask

    task automatic drive(input bit u, input bit e, input logic [3:0] r,
                         input logic [3:0] d, input bit c);
        bus.i_update      = u;
        bus.i_enable      = e;
        bus.i_task_req    = r;
        bus.i_task_done   = d;
        bus.i_clear_flags = c;
        step();
    endtask

    typedef struct {
        bit         u;
        bit         e;
        logic [3:0] r;
        logic [3:0] d;
        bit         c;
        logic [3:0] g;
        bit         b;
        bit         f;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit u, input bit e, input logic [3:0] r, input logic [3:0] d,
                                input bit c, input logic [3:0] g, input bit b, input bit f);
        vec_t v;
        v.u = u; v.e = e; v.r = r; v.d = d; v.c = c; v.g = g; v.b = b; v.f = f;
        tbl.push_back(v);
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int order[$];
        int last;
        bit seen3;
        int fd_cnt;
        bit quiet;

        // Grants 0,1,3 with done 3 cycles after each grant, then an empty window, then a disabled update.
        add(1,1,4'b1011,4'b0000,0, 4'b0000,1,0);
        add(0,1,4'b0100,4'b0000,0, 4'b0001,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0001,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0001,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0001,1,0);
        add(0,1,4'b0000,4'b0001,0, 4'b0000,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0000,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0010,1,0);
        add(0,1,4'b0000,4'b1101,0, 4'b0010,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0010,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0010,1,0);
        add(0,1,4'b0000,4'b0010,0, 4'b0000,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0000,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b1000,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b1000,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b1000,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b1000,1,0);
        add(0,1,4'b0000,4'b1000,0, 4'b0000,1,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0000,1,1);
        add(0,1,4'b0000,4'b0000,0, 4'b0000,0,0);
        add(1,1,4'b0000,4'b0000,0, 4'b0000,1,1);
        add(0,1,4'b0000,4'b0000,0, 4'b0000,0,0);
        add(1,0,4'b1111,4'b0000,0, 4'b0000,0,0);
        add(0,1,4'b0000,4'b0000,0, 4'b0000,0,0);

        model_reset();
        bus.i_update = 1'b0; bus.i_enable = 1'b1; bus.i_task_req = '0;
        bus.i_task_done = '0; bus.i_clear_flags = 1'b0;
        #2;
        chk("rst_grant",  int'(bus.o_task_grant), 0);
        chk("rst_busy",   int'(bus.o_busy), 0);
        chk("rst_fd",     int'(bus.o_frame_done), 0);
        chk("rst_flags",  int'(bus.o_timeout_flags), 0);
        chk("rst_ovr",    int'(bus.o_overrun_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].u, tbl[i].e, tbl[i].r, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d_grant", i), int'(bus.o_task_grant), int'(tbl[i].g));
            chk($sformatf("tbl%0d_busy", i),  int'(bus.o_busy), int'(tbl[i].b));
            chk($sformatf("tbl%0d_fd", i),    int'(bus.o_frame_done), int'(tbl[i].f));
        end

        // Task 2 never finishes: 16-cycle grant, sticky flag, then task 3 is served.
        drive(1,1,4'b1100,4'b0000,0);
        cnt = 0; seen3 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive(0,1,4'b0000,4'b0000,0);
            if (bus.o_task_grant == 4'b0100) cnt++;
            if (bus.o_task_grant == 4'b1000) begin seen3 = 1'b1; break; end
        end
        chk("to_len", cnt, 16);
        chk("to_next_task", int'(seen3), 1);
        chk("to_flags", int'(bus.o_timeout_flags), 4'b0100);
        drive(0,1,4'b0000,4'b1000,0);
        quiet = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(0,1,4'b0000,4'b0000,0);
            if (!bus.o_busy) begin quiet = 1'b1; break; end
        end
        chk("to_seq_end", int'(quiet), 1);

        // Done arriving in the last watchdog cycle ends the grant without a flag.
        drive(0,1,4'b0000,4'b0000,1);
        chk("clr_flags", int'(bus.o_timeout_flags), 0);
        drive(1,1,4'b0001,4'b0000,0);
        drive(0,1,4'b0000,4'b0000,0);
        for (int i = 0; i < 15; i++) drive(0,1,4'b0000,4'b0000,0);
        chk("edge_still_granted", int'(bus.o_task_grant), 4'b0001);
        drive(0,1,4'b0000,4'b0001,0);
        chk("edge_grant_drop", int'(bus.o_task_grant), 0);
        chk("edge_no_flag", int'(bus.o_timeout_flags), 0);
        repeat (3) drive(0,1,4'b0000,4'b0000,0);

        // Three overruns mid-sequence leave the grant order intact.
        drive(1,1,4'b1111,4'b0000,0);
        order.delete(); last = 0; quiet = 1'b0;
        for (int i = 0; i < 60; i++) begin
            drive((i == 2 || i == 6 || i == 9) ? 1'b1 : 1'b0, 1'b1, 4'($urandom),
                  (i % 3 == 2) ? bus.o_task_grant : 4'b0000, 1'b0);
            if (bus.o_task_grant != 4'b0000 && int'(bus.o_task_grant) != last)
                order.push_back($clog2(int'(bus.o_task_grant)));
            last = int'(bus.o_task_grant);
            if (!bus.o_busy) begin quiet = 1'b1; break; end
        end
        chk("ovr_seq_end", int'(quiet), 1);
        chk("ovr_order_len", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) chk($sformatf("ovr_order%0d", i), order[i], i);
        chk("ovr_cnt", int'(bus.o_overrun_cnt), 3);
        drive(0,1,4'b0000,4'b0000,1);
        chk("ovr_clear", int'(bus.o_overrun_cnt), 0);

        // Continuous updates over four all-timeout windows drive the counter into saturation.
        for (int s = 0; s < 4; s++) begin
            drive(1,1,4'b1111,4'b0000,0);
            quiet = 1'b0;
            for (int i = 0; i < 200; i++) begin
                drive(1,1,4'b1111,4'b0000,0);
                if (!bus.o_busy) begin quiet = 1'b1; break; end
            end
            chk("sat_seq_end", int'(quiet), 1);
        end
        chk("sat_ovr", int'(bus.o_overrun_cnt), 255);
        chk("sat_flags", int'(bus.o_timeout_flags), 4'b1111);
        drive(0,1,4'b0000,4'b0000,1);
        chk("sat_clear_ovr", int'(bus.o_overrun_cnt), 0);
        chk("sat_clear_flags", int'(bus.o_timeout_flags), 0);

        // Asynchronous reset in the middle of task 1's grant.
        drive(1,1,4'b0010,4'b0000,0);
        drive(0,1,4'b0000,4'b0000,0);
        chk("rst_pre_grant", int'(bus.o_task_grant), 4'b0010);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_grant", int'(bus.o_task_grant), 0);
        chk("rst_async_busy", int'(bus.o_busy), 0);
        model_reset();
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold_fd", int'(bus.o_frame_done), 0);
            chk("rst_hold_grant", int'(bus.o_task_grant), 0);
        end
        rst_n = 1'b1;
        drive(0,1,4'b0000,4'b0000,0);
        chk("rst_after_fd", int'(bus.o_frame_done), 0);
        drive(1,1,4'b0001,4'b0000,0);
        drive(0,1,4'b0000,4'b0000,0);
        chk("rst_restart_grant", int'(bus.o_task_grant), 4'b0001);
        fd_cnt = 0; quiet = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(0,1,4'b0000,bus.o_task_grant,0);
            if (bus.o_frame_done) fd_cnt++;
            if (!bus.o_busy) begin quiet = 1'b1; break; end
        end
        chk("rst_restart_end", int'(quiet), 1);
        chk("rst_restart_fd", fd_cnt, 1);

        // Random traffic, every cycle checked against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 20) == 0, ($urandom % 10) != 0, 4'($urandom),
                  (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000, ($urandom % 60) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
